// File: rtl/polar_encode_stream.sv
// Streaming polar encoder: collects K info bits, fills an N-bit frame from a frozen mask,
// runs one butterfly stage per cycle (twice in systematic mode) and streams N coded bits out.
module polar_encode_stream #(
  parameter int N = 2048,
  parameter int K = 1024,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] frozen_mask,
  input  logic         sys_mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_err,
  output logic         busy
);

  localparam int NW   = N / W;
  localparam int KW   = K / W;
  localparam int LOGN = $clog2(N);
  localparam int CW   = $clog2(N) + 1;
  localparam int PW   = $clog2(N + 1);
  localparam int KI   = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FILL,
    S_XFORM,
    S_CLEAR,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q;
  logic            err_q;
  logic            pass_q;

  logic [K-1:0]    info_q;
  logic [N-1:0]    mask_q;
  logic            sys_q;
  logic [N-1:0]    u_q;

  logic            in_hs, out_hs, last_word;
  logic [W-1:0]    mask_word, fill_word;
  logic [PW-1:0]   fill_ptr;
  logic [N-1:0]    xf_u;

  assign in_ready  = (state_q == S_LOAD) && rst_n;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = (state_q == S_OUT);
  assign out_hs    = out_valid && out_ready;
  assign last_word = (cnt_q == CW'(NW - 1));
  assign out_last  = out_valid && last_word;
  assign out_err   = out_valid && err_q;
  assign busy      = (state_q != S_LOAD);

  // Every state change restarts the shared word/stage counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (in_hs && cnt_q == CW'(KW - 1)) state_d = S_FILL;
      S_FILL:  if (cnt_q == CW'(NW - 1)) state_d = S_XFORM;
      S_XFORM: if (cnt_q == CW'(LOGN - 1)) state_d = (sys_q && !pass_q) ? S_CLEAR : S_OUT;
      S_CLEAR: state_d = S_XFORM;
      S_OUT:   if (out_hs && last_word) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_LOAD && in_hs) || (state_q == S_OUT && out_hs) ||
                 state_q == S_FILL || state_q == S_XFORM) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    logic [PW-1:0] p;
    mask_word = '0;
    for (int j = 0; j < NW; j++) begin
      if (cnt_q == CW'(j)) mask_word = mask_q[j*W +: W];
    end
    // NOTE: p is a running pointer inside one cycle, so it is updated with blocking assignments.
    p         = ptr_q;
    fill_word = '0;
    for (int b = 0; b < W; b++) begin
      if (!mask_word[b]) begin
        if (p < PW'(K)) fill_word[b] = info_q[p[KI-1:0]];
        p = p + PW'(1);
      end
    end
    fill_ptr = p;
  end

  // Stage s folds u[i+2^s] into u[i] wherever bit s of i is clear.
  always_comb begin
    xf_u = u_q;
    for (int s = 0; s < LOGN; s++) begin
      if (cnt_q == CW'(s)) begin
        for (int i = 0; i < N; i++) begin
          if (((i >> s) & 1) == 0) xf_u[i] = u_q[i] ^ u_q[i + (1 << s)];
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < NW; j++) begin
      if (cnt_q == CW'(j)) out_data = u_q[j*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unique case (state_q)
        S_LOAD: begin
          ptr_q  <= '0;
          pass_q <= 1'b0;
        end
        S_FILL: begin
          ptr_q <= fill_ptr;
          if (state_d == S_XFORM) err_q <= (fill_ptr != PW'(K));
        end
        S_CLEAR: pass_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: frame storage is deliberately left unreset; every bit is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      if (cnt_q == '0) begin
        mask_q <= frozen_mask;
        sys_q  <= sys_mode;
      end
      for (int j = 0; j < KW; j++) begin
        if (cnt_q == CW'(j)) info_q[j*W +: W] <= in_data;
      end
    end
    unique case (state_q)
      S_FILL: begin
        for (int j = 0; j < NW; j++) begin
          if (cnt_q == CW'(j)) u_q[j*W +: W] <= fill_word;
        end
      end
      S_XFORM: u_q <= xf_u;
      S_CLEAR: u_q <= u_q & ~mask_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_polar_encode_stream.sv
// Directed bench for polar_encode_stream at N=8, K=4, W=4 with hand-computed codewords.
module tb_polar_encode_stream;

  localparam int N = 8;
  localparam int K = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] frozen_mask;
  logic         sys_mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_err;
  logic         busy;

  int total  = 0;
  int passed = 0;

  polar_encode_stream #(.N(N), .K(K), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frozen_mask (frozen_mask),
    .sys_mode    (sys_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_err     (out_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-word frame: handshake, latency, both output words, return to LOAD.
  task automatic run_frame(input string tag, input logic [N-1:0] mask, input logic sys,
                           input logic [W-1:0] data, input int exp_lat, input logic [N-1:0] exp_x,
                           input logic exp_err, input int bp_cycles, input logic poke);
    int n;
    int cyc;
    frozen_mask = mask;
    sys_mode    = sys;
    in_data     = data;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    if (poke) begin
      frozen_mask = '1;
      sys_mode    = ~sys;
    end
    check({tag, "_busy"}, busy, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    for (int j = 0; j < N / W; j++) begin
      if (j == 0) begin
        out_ready = 1'b0;
        for (int b = 0; b < bp_cycles; b++) begin
          in_valid = 1'b1;
          check({tag, "_bp_valid"}, out_valid, 1'b1);
          check({tag, "_bp_data"}, out_data, exp_x[W-1:0]);
          check({tag, "_bp_last"}, out_last, 1'b0);
          check({tag, "_bp_in_ready"}, in_ready, 1'b0);
          step();
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_data"}, out_data, exp_x[j*W +: W]);
      check({tag, "_last"}, out_last, (j == N / W - 1));
      check({tag, "_err"}, out_err, exp_err);
      step();
    end
    check({tag, "_done_valid"}, out_valid, 1'b0);
    check({tag, "_done_in_ready"}, in_ready, 1'b1);
    check({tag, "_done_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    frozen_mask = 8'h17;
    sys_mode    = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    step();
    step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_err", out_err, 1'b0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1'b1);

    // Info positions 3,5,6,7; x[i] is the parity of u over all supersets of i.
    run_frame("ns1", 8'h17, 1'b0, 4'h1, 5, 8'h0F, 1'b0, 3, 1'b0);
    run_frame("nsF", 8'h17, 1'b0, 4'hF, 5, 8'h96, 1'b0, 0, 1'b1);
    run_frame("sy1", 8'h17, 1'b1, 4'h1, 9, 8'h0F, 1'b0, 0, 1'b0);
    run_frame("syF", 8'h17, 1'b1, 4'hF, 9, 8'hFF, 1'b0, 0, 1'b0);
    run_frame("err1", 8'h97, 1'b0, 4'h1, 5, 8'h0F, 1'b1, 0, 1'b0);
    run_frame("err8", 8'h97, 1'b0, 4'h8, 5, 8'h00, 1'b1, 0, 1'b0);
    run_frame("ok1", 8'h17, 1'b0, 4'h1, 5, 8'h0F, 1'b0, 0, 1'b0);

    // Abandon a frame while it is in the transform stages.
    frozen_mask = 8'h17;
    sys_mode    = 1'b0;
    in_data     = 4'hF;
    in_valid    = 1'b1;
    check("mid_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1'b1);
    check("mid_rel_out_valid", out_valid, 1'b0);
    run_frame("post", 8'h17, 1'b0, 4'h1, 5, 8'h0F, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
